// File: rtl/stu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stu_pkg
// Description : Shared types and constants for the speculative threading unit.
//               Provides the core-id type, the Level-2 controller state
//               encoding and small helpers shared by the L2 controller and its
//               worker arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package stu_pkg;

    localparam int NUM_CORES = 4;
    localparam int CORE_ID_W = $clog2(NUM_CORES);

    typedef logic [CORE_ID_W-1:0] core_id_t;

    // Core 0 is always the master; it never runs an L2 speculative task.
    localparam core_id_t MASTER_CORE_ID = '0;

    localparam int L2_TIMEOUT_DEFAULT = 1024;

    localparam int L2_STATE_W = 2;

    typedef enum logic [L2_STATE_W-1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2,
        SQUASH = 2'd3
    } stu_l2_state_t;

    // Next round-robin starting point: the worker after id, skipping core 0.
    function automatic core_id_t next_worker(input core_id_t id);
        if (int'(id) >= NUM_CORES - 1) begin
            return core_id_t'(1);
        end
        return id + core_id_t'(1);
    endfunction

    function automatic logic [NUM_CORES-1:0] core_onehot(input core_id_t id);
        logic [NUM_CORES-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stu_rr_worker_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stu_rr_worker_arbiter
// Description : Combinational masked round-robin choice of one idle worker.
//               Bit 0 (master) never takes part. The grant is the lowest idle
//               worker at or above ptr; if none, the lowest idle worker overall.
// Ports       : worker_idle - per-core idle flags (bit 0 ignored)
//               ptr         - round-robin starting core (1..NUM_CORES-1)
//               grant_valid - at least one worker is idle
//               grant_id    - chosen worker (MASTER_CORE_ID when none)
// Revision    : 1.0 - initial release
// ============================================================================
module stu_rr_worker_arbiter
    import stu_pkg::*;
(
    input  logic [NUM_CORES-1:0] worker_idle,
    input  core_id_t             ptr,
    output logic                 grant_valid,
    output core_id_t             grant_id
);

    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] mask;
    logic [NUM_CORES-1:0] masked;
    logic [NUM_CORES-1:0] sel;

    assign req = {worker_idle[NUM_CORES-1:1], 1'b0};

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_mask
        assign mask[gi] = (gi >= int'(ptr));
    end

    assign masked = req & mask;

    always_comb begin
        // Fall back to the unmasked set when nothing idle sits at/after ptr:
        // that is the wrap past NUM_CORES-1 back to core 1.
        sel         = (|masked) ? masked : req;
        grant_valid = |req;
        grant_id    = MASTER_CORE_ID;
        for (int i = NUM_CORES - 1; i >= 1; i--) begin
            if (sel[i]) begin
                grant_id = core_id_t'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stu_l2_spec_controller.sv
`default_nettype none
// ============================================================================
// Module      : stu_l2_spec_controller
// Description : Sequences one Level-2 (optimistic) speculative task at a time.
//               Grants an idle worker to a master fork request, drives the
//               memory tracker's active/core-id controls, and ends every task
//               with exactly one commit or squash pulse.
// Ports       : clk, rst (async, active-low)
//               fork_req_valid_in / fork_req_ready_out - fork handshake
//               worker_idle_in, spec_done_in, master_join_in, violation_in
//               spec_start_out, commit_out, squash_out - one-hot 1-cycle pulses
//               l2_spec_task_active_out, master_core_id_out,
//               l2_spec_core_id_out                  - tracker controls
//               commit_cnt_out, squash_cnt_out        - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module stu_l2_spec_controller
    import stu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = L2_TIMEOUT_DEFAULT,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fork_req_valid_in,
    output logic                 fork_req_ready_out,
    input  logic [NUM_CORES-1:0] worker_idle_in,
    input  logic [NUM_CORES-1:0] spec_done_in,
    input  logic                 master_join_in,
    input  logic                 violation_in,
    output logic [NUM_CORES-1:0] spec_start_out,
    output logic                 l2_spec_task_active_out,
    output core_id_t             master_core_id_out,
    output core_id_t             l2_spec_core_id_out,
    output logic [NUM_CORES-1:0] commit_out,
    output logic [NUM_CORES-1:0] squash_out,
    output logic [CNT_WIDTH-1:0] commit_cnt_out,
    output logic [CNT_WIDTH-1:0] squash_cnt_out
);

    localparam int                   TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    stu_l2_state_t        state;
    stu_l2_state_t        state_nxt;
    core_id_t             core_id;
    core_id_t             rr_ptr;
    logic [TIMER_W-1:0]   timer;
    logic                 done_seen;
    logic                 join_seen;
    logic                 start_pend;
    logic [CNT_WIDTH-1:0] commit_cnt;
    logic [CNT_WIDTH-1:0] squash_cnt;

    logic                 grant_valid;
    core_id_t             grant_id;
    logic                 accept;
    logic                 complete;

    stu_rr_worker_arbiter u_arb (
        .worker_idle (worker_idle_in),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign accept   = (state == IDLE) && fork_req_valid_in && grant_valid;
    // Same-cycle done/join count, so the task can finish on the cycle the
    // last event arrives rather than one cycle later.
    assign complete = (done_seen | spec_done_in[core_id]) & (join_seen | master_join_in);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                // Violation outranks completion; completion outranks timeout.
                if (violation_in)              state_nxt = SQUASH;
                else if (complete)             state_nxt = COMMIT;
                else if (timer == TIMER_LAST)  state_nxt = SQUASH;
            end
            COMMIT:  state_nxt = IDLE;
            SQUASH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- task bookkeeping ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_id    <= MASTER_CORE_ID;
            rr_ptr     <= core_id_t'(1);
            timer      <= '0;
            done_seen  <= 1'b0;
            join_seen  <= 1'b0;
            start_pend <= 1'b0;
            commit_cnt <= '0;
            squash_cnt <= '0;
        end else begin
            start_pend <= accept;
            if (accept) begin
                core_id   <= grant_id;
                rr_ptr    <= next_worker(grant_id);
                timer     <= '0;
                done_seen <= 1'b0;
                join_seen <= 1'b0;
            end
            if (state == RUN) begin
                timer     <= timer + TIMER_W'(1);
                done_seen <= done_seen | spec_done_in[core_id];
                join_seen <= join_seen | master_join_in;
            end
            if (state == COMMIT || state == SQUASH) begin
                done_seen <= 1'b0;
                join_seen <= 1'b0;
            end
            if (state == COMMIT && commit_cnt != '1) begin
                commit_cnt <= commit_cnt + CNT_WIDTH'(1);
            end
            if (state == SQUASH && squash_cnt != '1) begin
                squash_cnt <= squash_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        // Gate ready with rst so nothing is accepted while reset is held.
        fork_req_ready_out      = (state == IDLE) && grant_valid && rst;
        l2_spec_task_active_out = (state == RUN);
        spec_start_out          = start_pend ? core_onehot(core_id) : '0;
        commit_out              = (state == COMMIT) ? core_onehot(core_id) : '0;
        squash_out              = (state == SQUASH) ? core_onehot(core_id) : '0;
        master_core_id_out      = MASTER_CORE_ID;
        l2_spec_core_id_out     = core_id;
        commit_cnt_out          = commit_cnt;
        squash_cnt_out          = squash_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_stu_l2_spec_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_stu_l2_spec_controller
// Description : Self-checking bench for stu_l2_spec_controller. Directed task
//               scenarios followed by random traffic, all compared each cycle
//               against a task-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stu_l2_spec_controller;
    import stu_pkg::*;

    localparam int TMO = 12;
    localparam int CW  = 3;
    localparam int NC  = NUM_CORES;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fork_req_valid_in = 1'b0;
    logic          fork_req_ready_out;
    logic [NC-1:0] worker_idle_in = '0;
    logic [NC-1:0] spec_done_in = '0;
    logic          master_join_in = 1'b0;
    logic          violation_in = 1'b0;
    logic [NC-1:0] spec_start_out;
    logic          l2_spec_task_active_out;
    core_id_t      master_core_id_out;
    core_id_t      l2_spec_core_id_out;
    logic [NC-1:0] commit_out;
    logic [NC-1:0] squash_out;
    logic [CW-1:0] commit_cnt_out;
    logic [CW-1:0] squash_cnt_out;

    always #5 clk = ~clk;

    stu_l2_spec_controller #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .fork_req_valid_in       (fork_req_valid_in),
        .fork_req_ready_out      (fork_req_ready_out),
        .worker_idle_in          (worker_idle_in),
        .spec_done_in            (spec_done_in),
        .master_join_in          (master_join_in),
        .violation_in            (violation_in),
        .spec_start_out          (spec_start_out),
        .l2_spec_task_active_out (l2_spec_task_active_out),
        .master_core_id_out      (master_core_id_out),
        .l2_spec_core_id_out     (l2_spec_core_id_out),
        .commit_out              (commit_out),
        .squash_out              (squash_out),
        .commit_cnt_out          (commit_cnt_out),
        .squash_cnt_out          (squash_cnt_out)
    );

    int total = 0;
    int bad   = 0;

    // Task-level reference: is a task live, how many RUN cycles it has seen,
    // and which verdict (0 none, 1 commit, 2 squash) is to be announced.
    bit m_live    = 0;
    int m_age     = 0;
    int m_verdict = 0;
    int m_core    = 0;
    int m_ptr     = 1;
    bit m_done    = 0;
    bit m_join    = 0;
    int m_commits = 0;
    int m_squashes = 0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] oh(input int c);
        logic [NC-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // First idle worker at or after ptr, wrapping NC-1 -> 1; 0 means none.
    function automatic int pick(input int ptr, input logic [NC-1:0] idl);
        for (int k = 0; k < NC - 1; k++) begin
            int c;
            c = ((ptr - 1 + k) % (NC - 1)) + 1;
            if (idl[c]) return c;
        end
        return 0;
    endfunction

    function automatic int sat(input int n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    task automatic model_reset();
        m_live = 0; m_age = 0; m_verdict = 0; m_core = 0; m_ptr = 1;
        m_done = 0; m_join = 0; m_commits = 0; m_squashes = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check every
    // output against the model, then advance the model across the rising edge.
    task automatic step(input logic r, input logic v, input logic [NC-1:0] idl,
                        input logic [NC-1:0] dn, input logic jn, input logic vi);
        int            g;
        logic          e_ready, e_active;
        logic [NC-1:0] e_start, e_commit, e_squash;
        @(negedge clk);
        rst = r; fork_req_valid_in = v; worker_idle_in = idl;
        spec_done_in = dn; master_join_in = jn; violation_in = vi;
        #1;
        if (!r) model_reset();
        g = pick(m_ptr, idl);
        e_ready = 1'b0; e_active = 1'b0; e_start = '0; e_commit = '0; e_squash = '0;
        if (m_verdict == 1)      e_commit = oh(m_core);
        else if (m_verdict == 2) e_squash = oh(m_core);
        else if (m_live) begin
            e_active = 1'b1;
            if (m_age == 1) e_start = oh(m_core);
        end else begin
            e_ready = r && (g != 0);
        end
        check_value("ready",      32'(fork_req_ready_out),      32'(e_ready));
        check_value("active",     32'(l2_spec_task_active_out), 32'(e_active));
        check_value("start",      32'(spec_start_out),          32'(e_start));
        check_value("commit",     32'(commit_out),              32'(e_commit));
        check_value("squash",     32'(squash_out),              32'(e_squash));
        check_value("master_id",  32'(master_core_id_out),      32'(0));
        check_value("core_id",    32'(l2_spec_core_id_out),     32'(m_core));
        check_value("commit_cnt", 32'(commit_cnt_out),          32'(sat(m_commits)));
        check_value("squash_cnt", 32'(squash_cnt_out),          32'(sat(m_squashes)));
        if (r) begin
            if (m_verdict != 0) begin
                if (m_verdict == 1) m_commits++;
                else                m_squashes++;
                m_verdict = 0;
            end else if (m_live) begin
                m_done = m_done | dn[m_core];
                m_join = m_join | jn;
                if (vi)                  m_verdict = 2;
                else if (m_done && m_join) m_verdict = 1;
                else if (m_age == TMO)   m_verdict = 2;
                if (m_verdict != 0) m_live = 0;
                else                m_age++;
            end else if (v && g != 0) begin
                m_core = g;
                m_ptr  = (g == NC - 1) ? 1 : g + 1;
                m_live = 1; m_age = 1; m_done = 0; m_join = 0;
            end
        end
    endtask

    // Fork, then 'cycles' further cycles with done/join/violation placed on
    // the given RUN cycle numbers (0 = never).
    task automatic run_task(input logic [NC-1:0] idl, input int done_at, input int join_at,
                            input int viol_at, input int cycles);
        step(1'b1, 1'b1, idl, '0, 1'b0, 1'b0);
        for (int c = 1; c <= cycles; c++) begin
            step(1'b1, 1'b0, idl, (c == done_at) ? oh(m_core) : '0,
                 c == join_at, c == viol_at);
        end
    endtask

    initial begin
        logic [NC-1:0] ridl, rdn;
        // reset state
        repeat (3) step(1'b0, 1'b1, 4'b1111, '0, 1'b0, 1'b0);
        // basic commit: done on RUN cycle 5, join on 8
        run_task(4'b1111, 5, 8, 0, 10);
        // violation abort on RUN cycle 3
        run_task(4'b1111, 0, 0, 3, 5);
        // round-robin from reset: 1,2,3,1
        step(1'b0, 1'b0, 4'b1111, '0, 1'b0, 1'b0);
        repeat (4) run_task(4'b1111, 1, 1, 0, 2);
        // only core 3 idle
        run_task(4'b1000, 1, 1, 0, 3);
        // violation together with done and join
        run_task(4'b1111, 2, 2, 2, 4);
        // timeout with no done, then completion on the timeout cycle
        run_task(4'b1111, 0, 0, 0, TMO + 2);
        run_task(4'b1111, TMO, TMO, 0, TMO + 2);
        // no idle worker: ready stays low, then grant once one appears
        repeat (20) step(1'b1, 1'b1, 4'b0001, '0, 1'b0, 1'b0);
        run_task(4'b0101, 1, 2, 0, 4);
        // reset dropped in RUN
        run_task(4'b1111, 0, 0, 0, 3);
        repeat (2) step(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);
        // drive commit counter past saturation
        repeat (9) run_task(4'b1111, 1, 1, 0, 2);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            ridl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) ridl = 4'b0001;
            for (int b = 0; b < NC; b++) rdn[b] = ($urandom_range(0, 4) == 0);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, ridl, rdn,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
